// File: rtl/ysyx_25030093_pkg.sv
// Shared decode constants for the ysyx_25030093 instruction decode stage:
// opcodes, op classes, immediate formats and decoder states.
package ysyx_25030093_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        CLS_ALUR    = 4'd0,
        CLS_ALUI    = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_ILLEGAL = 4'd10
    } op_class_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HALT  = 2'd2
    } idu_state_e;

endpackage

// File: rtl/ysyx_25030093_imm_gen.sv
// Combinational immediate generator: assembles the RV32 immediate selected by
// imm_type and sign-extends it from inst[31] to XLEN bits.
module ysyx_25030093_imm_gen
    import ysyx_25030093_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;
    logic               unused_opcode_bits;

    assign unused_opcode_bits = ^inst[6:0];

    always_comb begin
        imm32 = '0;
        case (imm_type)
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed cast so a wider XLEN still sign-extends from bit 31.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/ysyx_25030093_idu.sv
// Instruction decode stage: one-entry registered decode slot between fetch and
// execute, halting permanently after an ebreak or illegal instruction drains.
module ysyx_25030093_idu
    import ysyx_25030093_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RVE    = 0,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_imm,
    output logic [3:0]        out_class,
    output logic [2:0]        out_funct3,
    output logic              out_funct7b5,
    output logic              out_wen,
    output logic              out_illegal,
    output logic              out_ebreak,
    output logic              halted
);

    idu_state_e state, state_nxt;

    // Stage p0: combinational decode of the incoming fetch bundle
    logic [6:0]        opcode, funct7;
    logic [2:0]        funct3;
    logic [4:0]        rs1_f, rs2_f, rd_f;
    logic              use_rs1, use_rs2, use_rd, legal, rve_bad;
    op_class_e         cls_p0;
    imm_type_e         imm_type_p0;
    logic              ebreak_p0, illegal_p0, wen_p0;
    logic [REG_AW-1:0] rs1_p0, rs2_p0, rd_p0;
    logic [XLEN-1:0]   imm_p0;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rs1_f  = in_inst[19:15];
    assign rs2_f  = in_inst[24:20];
    assign rd_f   = in_inst[11:7];

    always_comb begin
        cls_p0      = CLS_ILLEGAL;
        imm_type_p0 = IMM_NONE;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        use_rd      = 1'b0;
        ebreak_p0   = 1'b0;
        legal       = 1'b0;
        case (opcode)
            OP_LUI:   begin legal = 1'b1; cls_p0 = CLS_LUI;   imm_type_p0 = IMM_U; use_rd = 1'b1; end
            OP_AUIPC: begin legal = 1'b1; cls_p0 = CLS_AUIPC; imm_type_p0 = IMM_U; use_rd = 1'b1; end
            OP_JAL:   begin legal = 1'b1; cls_p0 = CLS_JAL;   imm_type_p0 = IMM_J; use_rd = 1'b1; end
            OP_JALR: begin
                legal = (funct3 == 3'b000);
                cls_p0 = CLS_JALR; imm_type_p0 = IMM_I; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OP_BRANCH: begin
                legal = !(funct3 inside {3'b010, 3'b011});
                cls_p0 = CLS_BRANCH; imm_type_p0 = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_LOAD: begin
                legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                cls_p0 = CLS_LOAD; imm_type_p0 = IMM_I; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OP_STORE: begin
                legal = funct3 inside {3'b000, 3'b001, 3'b010};
                cls_p0 = CLS_STORE; imm_type_p0 = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_ALUI: begin
                // Shift-immediates reuse imm[11:5] as funct7, so it must be a known encoding.
                if (funct3 == 3'b001)      legal = (funct7 == FUNCT7_BASE);
                else if (funct3 == 3'b101) legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                else                       legal = 1'b1;
                cls_p0 = CLS_ALUI; imm_type_p0 = IMM_I; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OP_ALUR: begin
                legal = (funct7 == FUNCT7_BASE) ||
                        ((funct7 == FUNCT7_ALT) && (funct3 inside {3'b000, 3'b101}));
                cls_p0 = CLS_ALUR; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            end
            OP_SYSTEM: begin
                legal     = (in_inst == INST_EBREAK) || (in_inst == INST_ECALL);
                ebreak_p0 = (in_inst == INST_EBREAK);
                cls_p0    = CLS_SYSTEM;
            end
            default: legal = 1'b0;
        endcase

        rve_bad = (RVE != 0) &&
                  ((use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) || (use_rd && rd_f[4]));
        illegal_p0 = !legal || rve_bad;

        // An illegal bundle carries only pc (and funct fields) for trap reporting.
        if (illegal_p0) begin
            cls_p0      = CLS_ILLEGAL;
            imm_type_p0 = IMM_NONE;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
            use_rd      = 1'b0;
            ebreak_p0   = 1'b0;
        end

        rs1_p0 = use_rs1 ? REG_AW'(rs1_f) : '0;
        rs2_p0 = use_rs2 ? REG_AW'(rs2_f) : '0;
        rd_p0  = use_rd  ? REG_AW'(rd_f)  : '0;
        wen_p0 = use_rd && (rd_f != 5'd0);
    end

    ysyx_25030093_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .inst    (in_inst),
        .imm_type(imm_type_p0),
        .imm     (imm_p0)
    );

    // Stage p1: registered decode bundle and handshake control
    logic              accept;
    logic [XLEN-1:0]   pc_p1, imm_p1;
    logic [REG_AW-1:0] rs1_p1, rs2_p1, rd_p1;
    op_class_e         cls_p1;
    logic [2:0]        funct3_p1;
    logic              funct7b5_p1, wen_p1, illegal_p1, ebreak_p1;

    assign in_ready = (state == ST_EMPTY) ||
                      ((state == ST_FULL) && out_ready && !ebreak_p1 && !illegal_p1);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_FULL;
            ST_FULL: begin
                if (out_ready) begin
                    if (ebreak_p1 || illegal_p1) state_nxt = ST_HALT;
                    else if (accept)             state_nxt = ST_FULL;
                    else                         state_nxt = ST_EMPTY;
                end
            end
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_EMPTY;
            pc_p1       <= '0;
            imm_p1      <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            cls_p1      <= CLS_ALUR;
            funct3_p1   <= '0;
            funct7b5_p1 <= 1'b0;
            wen_p1      <= 1'b0;
            illegal_p1  <= 1'b0;
            ebreak_p1   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pc_p1       <= in_pc;
                imm_p1      <= imm_p0;
                rs1_p1      <= rs1_p0;
                rs2_p1      <= rs2_p0;
                rd_p1       <= rd_p0;
                cls_p1      <= cls_p0;
                funct3_p1   <= funct3;
                funct7b5_p1 <= in_inst[30];
                wen_p1      <= wen_p0;
                illegal_p1  <= illegal_p0;
                ebreak_p1   <= ebreak_p0;
            end
        end
    end

    assign out_valid    = (state == ST_FULL);
    assign halted       = (state == ST_HALT);
    assign out_pc       = pc_p1;
    assign out_imm      = imm_p1;
    assign out_rs1      = rs1_p1;
    assign out_rs2      = rs2_p1;
    assign out_rd       = rd_p1;
    assign out_class    = cls_p1;
    assign out_funct3   = funct3_p1;
    assign out_funct7b5 = funct7b5_p1;
    assign out_wen      = wen_p1;
    assign out_illegal  = illegal_p1;
    assign out_ebreak   = ebreak_p1;

endmodule

// File: tb/tb_ysyx_25030093_idu.sv
// Directed bench for ysyx_25030093_idu: an RV32I instance and an RV32E
// instance driven from the same fetch stream.
module tb_ysyx_25030093_idu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_funct7b5, out_wen, out_illegal, out_ebreak, halted;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [3:0]  out_class;
    logic [2:0]  out_funct3;

    logic        e_in_ready, e_out_valid, e_out_funct7b5, e_out_wen, e_out_illegal, e_out_ebreak, e_halted;
    logic [31:0] e_out_pc, e_out_imm;
    logic [4:0]  e_out_rs1, e_out_rs2, e_out_rd;
    logic [3:0]  e_out_class;
    logic [2:0]  e_out_funct3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_25030093_idu #(.XLEN(32), .RVE(0), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_class(out_class), .out_funct3(out_funct3),
        .out_funct7b5(out_funct7b5), .out_wen(out_wen), .out_illegal(out_illegal),
        .out_ebreak(out_ebreak), .halted(halted)
    );

    ysyx_25030093_idu #(.XLEN(32), .RVE(1), .REG_AW(5)) dut_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(e_out_valid), .out_ready(out_ready),
        .out_pc(e_out_pc), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_rd(e_out_rd),
        .out_imm(e_out_imm), .out_class(e_out_class), .out_funct3(e_out_funct3),
        .out_funct7b5(e_out_funct7b5), .out_wen(e_out_wen), .out_illegal(e_out_illegal),
        .out_ebreak(e_out_ebreak), .halted(e_halted)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    initial begin
        #2 rst = 1'b0;
        tick();
        tick();
        check("rst out_valid", out_valid, 0);
        check("rst halted", halted, 0);
        check("rst out_pc", out_pc, 0);
        check("rst out_imm", out_imm, 0);
        rst = 1'b1;
        #1;
        check("post-rst in_ready", in_ready, 1);

        // addi x1,x0,5
        out_ready = 1'b1;
        drive(1, 32'h8000_0000, 32'h0050_0093);
        tick();
        check("addi out_valid", out_valid, 1);
        check("addi class", out_class, 1);
        check("addi rd", out_rd, 1);
        check("addi rs1", out_rs1, 0);
        check("addi imm", out_imm, 5);
        check("addi wen", out_wen, 1);
        check("addi pc", out_pc, 32'h8000_0000);

        // sw x2,8(x1) then beq x0,x0,-4 back to back
        drive(1, 32'h8000_0004, 32'h0020_A423);
        tick();
        check("sw out_valid", out_valid, 1);
        check("sw class", out_class, 3);
        check("sw rs1", out_rs1, 1);
        check("sw rs2", out_rs2, 2);
        check("sw rd", out_rd, 0);
        check("sw imm", out_imm, 8);
        check("sw wen", out_wen, 0);
        drive(1, 32'h8000_0008, 32'hFE00_0EE3);
        tick();
        check("beq out_valid", out_valid, 1);
        check("beq class", out_class, 4);
        check("beq imm", out_imm, 32'hFFFF_FFFC);
        check("beq rd", out_rd, 0);
        check("beq pc", out_pc, 32'h8000_0008);

        // lui x5,0x12345 held under backpressure
        drive(1, 32'h8000_000C, 32'h1234_52B7);
        tick();
        out_ready = 1'b0;
        drive(1, 32'h8000_0010, 32'hFFFF_FFFF);
        #1;
        check("lui in_ready", in_ready, 0);
        check("lui class", out_class, 7);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold out_valid", out_valid, 1);
            check("hold in_ready", in_ready, 0);
            check("hold imm", out_imm, 32'h1234_5000);
            check("hold rd", out_rd, 5);
            check("hold pc", out_pc, 32'h8000_000C);
            check("hold wen", out_wen, 1);
        end
        drive(0, 32'h0, 32'h0);
        out_ready = 1'b1;
        tick();
        check("drain out_valid", out_valid, 0);
        check("drain in_ready", in_ready, 1);

        // ebreak then permanent halt
        drive(1, 32'h0000_0100, 32'h0010_0073);
        tick();
        check("ebreak out_valid", out_valid, 1);
        check("ebreak flag", out_ebreak, 1);
        check("ebreak class", out_class, 9);
        check("ebreak in_ready", in_ready, 0);
        drive(1, 32'h0000_0104, 32'h0050_0093);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halt halted", halted, 1);
            check("halt out_valid", out_valid, 0);
            check("halt in_ready", in_ready, 0);
        end

        // async reset out of HALT
        #2 rst = 1'b0;
        #1;
        check("areset halted", halted, 0);
        check("areset out_valid", out_valid, 0);
        check("areset out_ebreak", out_ebreak, 0);
        check("areset out_pc", out_pc, 0);
        drive(0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        check("areset in_ready", in_ready, 1);

        // all-zero word is illegal
        drive(1, 32'h0000_0200, 32'h0000_0000);
        tick();
        check("illegal out_valid", out_valid, 1);
        check("illegal flag", out_illegal, 1);
        check("illegal class", out_class, 10);
        check("illegal pc", out_pc, 32'h0000_0200);
        check("illegal imm", out_imm, 0);
        check("illegal wen", out_wen, 0);
        check("illegal in_ready", in_ready, 0);
        drive(0, 32'h0, 32'h0);
        tick();
        check("illegal halted", halted, 1);
        check("illegal halt out_valid", out_valid, 0);
        #2 rst = 1'b0;
        #1;
        check("areset2 halted", halted, 0);
        check("areset2 illegal", out_illegal, 0);
        check("areset2 pc", out_pc, 0);
        check("areset2 class", out_class, 0);
        tick();
        rst = 1'b1;
        #1;
        check("areset2 in_ready", in_ready, 1);

        // ecall, sub x3,x1,x2, addi x16,x0,16
        drive(1, 32'h0000_0300, 32'h0000_0073);
        tick();
        check("ecall class", out_class, 9);
        check("ecall ebreak", out_ebreak, 0);
        check("ecall illegal", out_illegal, 0);
        check("ecall in_ready", in_ready, 1);
        drive(1, 32'h0000_0304, 32'h4020_81B3);
        tick();
        check("sub class", out_class, 0);
        check("sub rd", out_rd, 3);
        check("sub rs1", out_rs1, 1);
        check("sub rs2", out_rs2, 2);
        check("sub imm", out_imm, 0);
        check("sub funct7b5", out_funct7b5, 1);
        check("sub wen", out_wen, 1);
        drive(1, 32'h0000_0308, 32'h0100_0813);
        tick();
        drive(0, 32'h0, 32'h0);
        check("rvi x16 illegal", out_illegal, 0);
        check("rvi x16 rd", out_rd, 16);
        check("rvi x16 imm", out_imm, 16);
        check("rvi x16 wen", out_wen, 1);
        check("rve x16 out_valid", e_out_valid, 1);
        check("rve x16 illegal", e_out_illegal, 1);
        check("rve x16 class", e_out_class, 10);
        check("rve x16 rd", e_out_rd, 0);
        check("rve x16 imm", e_out_imm, 0);
        check("rve x16 wen", e_out_wen, 0);
        check("rve x16 pc", e_out_pc, 32'h0000_0308);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25030093_idu.md
Name: ysyx_25030093_idu

Overview:
Instruction decode stage. It sits directly downstream of the SRAM-backed instruction fetch unit. It accepts {pc, inst} over a valid/ready handshake, decodes one RV32I/E instruction into a registered bundle, and presents that bundle to the execute stage over a second valid/ready handshake. After an ebreak or an illegal instruction it stops accepting fetches until reset.

Parameters:
XLEN, 32, datapath and pc width
RVE, 0, 1 = RV32E: any used register index with bit 4 set marks the instruction illegal
REG_AW, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  fetch bundle valid
in_ready  out  1  decoder can accept a bundle this cycle
in_pc  in  XLEN  pc of fetched instruction
in_inst  in  32  fetched instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute stage accepts the bundle
out_pc  out  XLEN  registered pc
out_rs1, out_rs2, out_rd  out  REG_AW  register indices (0 when unused)
out_imm  out  XLEN  sign-extended immediate, 0 for R-type
out_class  out  4  op class enum (see package)
out_funct3  out  3  passthrough funct3
out_funct7b5  out  1  inst[30]
out_wen  out  1  rd write enable (0 if rd==0)
out_illegal  out  1  undecodable instruction
out_ebreak  out  1  instruction is ebreak
halted  out  1  decoder in HALT state

Behaviour:
- Reset (rst low, async): state=EMPTY; all out_* and halted = 0; in_ready=1 on the first cycle after release.
- States: EMPTY, FULL, HALT.
- in_ready = (state==EMPTY) | (state==FULL & out_ready & !out_ebreak & !out_illegal). Always 0 in HALT.
- Accept = in_valid & in_ready. On accept, the decoded bundle is registered; out_valid=1 from the next cycle. Latency is 1 cycle. A back-to-back accept and drain gives 1 instruction/cycle.
- EMPTY: accept goes to FULL.
- FULL with out_ready=0: hold. All out_* stay bit-stable and in_ready=0.
- FULL with out_ready=1:
  - If the current bundle is ebreak or illegal, go to HALT. out_valid=0.
  - Else if accept, stay FULL with the new bundle.
  - Else go to EMPTY.
- HALT: out_valid=0, halted=1, in_ready=0. Only reset leaves HALT.
- Classes by opcode:
  - LUI 0110111 → U-type
  - AUIPC 0010111 → U-type
  - JAL 1101111 → J-type
  - JALR 1100111 (funct3 must be 0) → I-type
  - BRANCH 1100011 (funct3 010/011 illegal) → B-type
  - LOAD 0000011 (funct3 000/001/010/100/101) → I-type
  - STORE 0100011 (funct3 000/001/010) → S-type
  - ALUI 0010011 (slli requires funct7 0000000; srli/srai require funct7 0000000/0100000) → I-type
  - ALUR 0110011 (funct7 0000000, or 0100000 only for add/sub and srl/sra) → R-type
  - SYSTEM 1110011: only 0x00100073 is ebreak; ecall 0x00000073 is class SYSTEM with ebreak=0.
  - Anything else → ILLEGAL, out_illegal=1.
- Immediates, sign-extended from inst[31]:
  - I = inst[31:20]
  - S = {inst[31:25], inst[11:7]}
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U = {inst[31:12], 12'b0}
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- Register fields:
  - out_rs1 = 0 for U/J.
  - out_rs2 = 0 for I/U/J.
  - out_rd = 0 for S/B.
  - out_wen = (rd field used) & (rd != 0).
- Illegal bundle: out_rs1, out_rs2, out_rd, out_imm and out_wen are all 0. out_pc is still valid for trap reporting.
- in_inst and in_pc are sampled only on accept. Values while in_ready=0 are ignored.
- Reset asserted mid-transfer drops the held bundle; there is no partial output.

Decomposition:
- Package ysyx_25030093_pkg holds:
  - opcode constants (OP_LUI … OP_SYSTEM);
  - the op class enum: CLS_ALUR=0, CLS_ALUI, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_SYSTEM, CLS_ILLEGAL;
  - the imm-type enum: IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J;
  - the EBREAK encoding constant.
- One combinational sub-module, ysyx_25030093_imm_gen: inputs inst and imm type, output XLEN immediate.
- Decode logic and the state register stay in the top module.

Test Plan:
- Reset, then in_pc=0x80000000, in_inst=0x00500093 (addi x1,x0,5), out_ready=1 → next cycle out_valid=1, class ALUI, rd=1, rs1=0, imm=5, wen=1, out_pc=0x80000000.
- 0x0020A423 (sw x2,8(x1)) then 0xFE000EE3 (beq x0,x0,-4) on consecutive cycles → two consecutive out_valid cycles:
  - first: STORE, rs1=1, rs2=2, imm=8, wen=0;
  - second: BRANCH, imm=0xFFFFFFFC.
- 0x123452B7 (lui x5,0x12345) with out_ready=0 for 3 cycles → in_ready=0 and outputs bit-stable (imm=0x12345000, rd=5) throughout; the bundle drains on the cycle out_ready=1.
- 0x00100073 → out_ebreak=1 for one handshake, then halted=1, in_ready=0 and out_valid=0 for 10+ cycles despite in_valid=1.
- 0x00000000 → out_illegal=1, class ILLEGAL, out_pc correct, then HALT. Asserting rst low mid-HALT (asynchronously) → all outputs 0 immediately, in_ready=1 after release.
- With RVE=1, 0x01000813 (addi x16,x0,16) → out_illegal=1. With RVE=0, the same word gives rd=16, imm=16.
